// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding and opcode width shared by the ALU, RS and decoder.
package alu_pkg;
  localparam int OP_BIT = 4;
  typedef enum logic [OP_BIT-1:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_EQ, ALU_NE, ALU_GE, ALU_GEU, ALU_PASS, ALU_LHS
  } alu_op_e;
endpackage

// File: rtl/alu_unit_if.sv
// alu_unit_if: RS issue handshake and CDB broadcast handshake of the ALU.
interface alu_unit_if import alu_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_BIT = 4
);
  logic in_valid;
  logic in_ready;
  logic [OP_BIT-1:0] in_op;
  logic [DATA_WIDTH-1:0] in_lhs;
  logic [DATA_WIDTH-1:0] in_rhs;
  logic [ROB_BIT-1:0] in_rob_id;
  logic cdb_valid;
  logic cdb_grant;
  logic [ROB_BIT-1:0] cdb_rob_id;
  logic [DATA_WIDTH-1:0] cdb_data;
  modport master (
    output in_valid, in_op, in_lhs, in_rhs, in_rob_id, cdb_grant,
    input in_ready, cdb_valid, cdb_rob_id, cdb_data
  );
  modport slave (
    input in_valid, in_op, in_lhs, in_rhs, in_rob_id, cdb_grant,
    output in_ready, cdb_valid, cdb_rob_id, cdb_data
  );
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: result queue with independent wrapping pointers and a count
// register that distinguishes full from empty; flush empties it synchronously.
module alu_result_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0] count,
  output logic full,
  output logic empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/alu_unit.sv
// alu_unit: pipelined integer execution unit; one registered compute stage
// feeding a result queue that broadcasts {rob_id, data} on the CDB.
module alu_unit import alu_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_BIT = 4,
  parameter int OUT_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  input logic flush,
  alu_unit_if.slave bus
);
  localparam int SH = $clog2(DATA_WIDTH);
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int W = ROB_BIT + DATA_WIDTH;
  function automatic logic [DATA_WIDTH-1:0] calc(input logic [OP_BIT-1:0] op,
                                                 input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic [SH-1:0] sh;
    sh = b[SH-1:0];
    case (alu_op_e'(op))
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return DATA_WIDTH'($signed(a) >>> sh);
      ALU_SLT:  return DATA_WIDTH'($signed(a) < $signed(b));
      ALU_SLTU: return DATA_WIDTH'(a < b);
      ALU_EQ:   return DATA_WIDTH'(a == b);
      ALU_NE:   return DATA_WIDTH'(a != b);
      ALU_GE:   return DATA_WIDTH'($signed(a) >= $signed(b));
      ALU_GEU:  return DATA_WIDTH'(a >= b);
      ALU_PASS: return b;
      default:  return a;
    endcase
  endfunction
  logic s1_valid;
  logic [DATA_WIDTH-1:0] s1_result;
  logic [ROB_BIT-1:0] s1_rob_id;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  logic full, empty, accept;
  logic [W-1:0] head;
  // Ready counts the op still in stage 1 so its push always finds room.
  assign occ = {1'b0, count} + {{CW{1'b0}}, s1_valid};
  assign bus.in_ready = occ < (CW + 1)'(OUT_DEPTH);
  assign accept = bus.in_valid && bus.in_ready && !flush;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_result <= '0;
      s1_rob_id <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_result <= calc(bus.in_op, bus.in_lhs, bus.in_rhs);
        s1_rob_id <= bus.in_rob_id;
      end
    end
  end
  alu_result_fifo #(.WIDTH(W), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .push(s1_valid && !full),
    .pop(bus.cdb_grant),
    .din({s1_rob_id, s1_result}),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  assign bus.cdb_valid = !empty;
  assign {bus.cdb_rob_id, bus.cdb_data} = head;
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and random stimulus with a scoreboard of expected
// {rob_id, data} pairs checked at each CDB head.
module tb_alu_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic tog = 1'b0;
  int total = 0;
  int bad = 0;
  logic [35:0] sb[$];
  always #5 clk = ~clk;
  alu_unit_if #(.DATA_WIDTH(32), .ROB_BIT(4)) bus();
  alu_unit #(.DATA_WIDTH(32), .ROB_BIT(4), .OUT_DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus)
  );
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] t;
    logic [31:0] as, bs;
    as = a ^ 32'h8000_0000;
    bs = b ^ 32'h8000_0000;
    t = {{32{a[31]}}, a} >> b[4:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a + ~b + 32'd1;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return t[31:0];
      4'd8:  return {31'd0, as < bs};
      4'd9:  return {31'd0, a < b};
      4'd10: return {31'd0, a == b};
      4'd11: return {31'd0, a != b};
      4'd12: return {31'd0, !(as < bs)};
      4'd13: return {31'd0, !(a < b)};
      4'd14: return b;
      default: return a;
    endcase
  endfunction
  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    if (tog) bus.cdb_grant = !bus.cdb_grant;
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] exp);
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_lhs = a;
    bus.in_rhs = b;
    bus.in_rob_id = tag;
    for (int i = 0; i < 50 && !bus.in_ready; i++) step();
    total++;
    assert (bus.in_ready) else begin
      bad++;
      $error("FAIL issue_timeout observed=in_ready 0 expected=1 tag=%0h", tag);
    end
    sb.push_back({tag, exp});
    step();
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) step();
    check("drain_left", 64'(sb.size()), 64'd0);
    check("drain_idle", 64'(bus.cdb_valid), 64'd0);
  endtask
  always @(negedge clk) begin
    if (rst && bus.cdb_valid) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL cdb_extra observed=%0h:%0h expected=none", bus.cdb_rob_id, bus.cdb_data);
      end
      if (sb.size() != 0) begin
        check("cdb_head", 64'({bus.cdb_rob_id, bus.cdb_data}), 64'(sb[0]));
        if (bus.cdb_grant) void'(sb.pop_front());
      end
    end
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_op = '0;
    bus.in_lhs = '0;
    bus.in_rhs = '0;
    bus.in_rob_id = '0;
    bus.cdb_grant = 1'b0;
    step();
    check("rst_valid", 64'(bus.cdb_valid), 64'd0);
    check("rst_tag", 64'(bus.cdb_rob_id), 64'd0);
    check("rst_data", 64'(bus.cdb_data), 64'd0);
    step();
    rst = 1'b1;
    step();
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    // ADD wraps; two-cycle latency with grant held high
    bus.cdb_grant = 1'b1;
    issue(4'd0, 32'hFFFF_FFFF, 32'd1, 4'd3, 32'h0);
    check("lat_n1", 64'(bus.cdb_valid), 64'd0);
    step();
    check("lat_n2_valid", 64'(bus.cdb_valid), 64'd1);
    check("lat_n2_tag", 64'(bus.cdb_rob_id), 64'd3);
    check("lat_n2_data", 64'(bus.cdb_data), 64'd0);
    step();
    check("lat_after_pop", 64'(bus.cdb_valid), 64'd0);
    // shift amount uses only low 5 bits; signed vs unsigned compare
    issue(4'd7, 32'h8000_0000, 32'h0000_0024, 4'd5, 32'hF800_0000);
    issue(4'd8, 32'hFFFF_FFFF, 32'd1, 4'd6, 32'd1);
    issue(4'd9, 32'hFFFF_FFFF, 32'd1, 4'd7, 32'd0);
    issue(4'd12, 32'hFFFF_FFFF, 32'd1, 4'd8, 32'd0);
    issue(4'd13, 32'hFFFF_FFFF, 32'd1, 4'd9, 32'd1);
    issue(4'd14, 32'h1234_5000, 32'hABCD_E000, 4'd10, 32'hABCD_E000);
    drain();
    // back-to-back with no grant: ready drops after two accepts
    bus.cdb_grant = 1'b0;
    issue(4'd0, 32'd10, 32'd1, 4'd1, 32'd11);
    check("b2b_ready1", 64'(bus.in_ready), 64'd1);
    issue(4'd1, 32'd10, 32'd1, 4'd2, 32'd9);
    check("b2b_ready2", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_op = 4'd2;
    bus.in_rob_id = 4'd3;
    step();
    check("b2b_full_ready", 64'(bus.in_ready), 64'd0);
    check("b2b_full_valid", 64'(bus.cdb_valid), 64'd1);
    bus.cdb_grant = 1'b1;
    issue(4'd2, 32'hF0F0, 32'hFF00, 4'd3, 32'hF000);
    issue(4'd3, 32'hF0F0, 32'h0F0F, 4'd4, 32'hFFFF);
    drain();
    // random ops with grant toggling each cycle
    bus.cdb_grant = 1'b0;
    tog = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [3:0] op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = (i % 3 == 0) ? a : $urandom;
      issue(op, a, b, 4'(i), model(op, a, b));
    end
    drain();
    tog = 1'b0;
    // flush with a queued entry and one in stage 1
    bus.cdb_grant = 1'b0;
    issue(4'd4, 32'hAAAA, 32'h5555, 4'd11, 32'hFFFF);
    step();
    issue(4'd5, 32'd1, 32'd4, 4'd12, 32'd16);
    check("fl_pre_valid", 64'(bus.cdb_valid), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_rob_id = 4'd13;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    check("fl_valid", 64'(bus.cdb_valid), 64'd0);
    check("fl_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_rob_id = 4'd14;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.cdb_grant = 1'b1;
    step();
    check("fl_noacc1", 64'(bus.cdb_valid), 64'd0);
    step();
    check("fl_noacc2", 64'(bus.cdb_valid), 64'd0);
    // asynchronous reset while a result is waiting
    bus.cdb_grant = 1'b0;
    issue(4'd0, 32'd5, 32'd6, 4'd1, 32'd11);
    issue(4'd0, 32'd7, 32'd8, 4'd2, 32'd15);
    check("mr_pre_valid", 64'(bus.cdb_valid), 64'd1);
    #1 rst = 1'b0;
    #1;
    sb.delete();
    check("mr_valid", 64'(bus.cdb_valid), 64'd0);
    check("mr_tag", 64'(bus.cdb_rob_id), 64'd0);
    check("mr_data", 64'(bus.cdb_data), 64'd0);
    bus.cdb_grant = 1'b1;
    step();
    step();
    rst = 1'b1;
    check("mr_ready", 64'(bus.in_ready), 64'd1);
    check("mr_idle", 64'(bus.cdb_valid), 64'd0);
    issue(4'd10, 32'd9, 32'd9, 4'd9, 32'd1);
    check("mr_lat1", 64'(bus.cdb_valid), 64'd0);
    step();
    check("mr_lat2", 64'(bus.cdb_valid), 64'd1);
    check("mr_lat2_data", 64'(bus.cdb_data), 64'd1);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
